// File: rtl/sr_bank_arbiter_pkg.sv
// Shared opcodes and controller state encoding for the sr_ff bank arbiter.
package sr_bank_arbiter_pkg;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_CLR = 2'b01;
   localparam logic [1:0] OP_SET = 2'b10;
   localparam logic [1:0] OP_TGL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Port identifiers; last_grant holds one of these.
   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/sr_bank_arbiter_sr_ff.sv
// Single set/reset storage cell with synchronous active-high reset.
module sr_ff (
   input  logic clk,
   input  logic rst,
   input  logic s_i,
   input  logic r_i,
   output logic q_o
);

   logic q_q;

   // The controller guarantees s_i and r_i are never both high.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= 1'b0;
      end else if (s_i) begin
         q_q <= 1'b1;
      end else if (r_i) begin
         q_q <= 1'b0;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/sr_bank_arbiter.sv
// Two-port round-robin arbiter that serialises set/clear/toggle commands into
// single-cycle, mutually exclusive s/r pulses on a bank of sr_ff cells.
module sr_bank_arbiter
   import sr_bank_arbiter_pkg::*;
#(
   parameter int N_CELLS = 8,
   parameter int IDX_W   = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0_valid,
   input  logic [1:0]         req0_op,
   input  logic [IDX_W-1:0]   req0_idx,
   output logic               req0_ready,
   input  logic               req1_valid,
   input  logic [1:0]         req1_op,
   input  logic [IDX_W-1:0]   req1_idx,
   output logic               req1_ready,
   output logic               done,
   output logic               done_id,
   output logic               done_err,
   output logic               busy,
   output logic [N_CELLS-1:0] q
);

   if ((N_CELLS < 1) || (N_CELLS > 256) || ((2 ** IDX_W) < N_CELLS)) begin : g_param_check
      $error("sr_bank_arbiter: N_CELLS must be 1..256 and fit in IDX_W bits");
   end

   state_e             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               port_q, port_d;
   logic               last_grant_q, last_grant_d;

   logic               grant0, grant1;
   logic               idx_oob;
   logic [N_CELLS-1:0] s_vec, r_vec;

   // Handshake: a command transfers on a clk edge where valid && ready.
   // ready is combinational, high only in IDLE and only for the granted port;
   // requesters keep valid/op/idx stable until that edge.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == ST_IDLE) begin
         if (req0_valid && (!req1_valid || (last_grant_q == PORT1))) begin
            grant0 = 1'b1;
         end else if (req1_valid) begin
            grant1 = 1'b1;
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      idx_d        = idx_q;
      port_d       = port_q;
      last_grant_d = last_grant_q;
      case (state_q)
         ST_IDLE: begin
            if (grant0 || grant1) begin
               op_d         = grant1 ? req1_op  : req0_op;
               idx_d        = grant1 ? req1_idx : req0_idx;
               port_d       = grant1 ? PORT1    : PORT0;
               last_grant_d = grant1 ? PORT1    : PORT0;
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_NOP;
         idx_q        <= '0;
         port_q       <= PORT0;
         last_grant_q <= PORT1;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         idx_q        <= idx_d;
         port_q       <= port_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign idx_oob = (32'(idx_q) >= 32'(N_CELLS));

   // At most one cell is driven, and only during ISSUE; toggle uses the live q.
   always_comb begin
      s_vec = '0;
      r_vec = '0;
      if ((state_q == ST_ISSUE) && !idx_oob) begin
         for (int i = 0; i < N_CELLS; i++) begin
            if (idx_q == IDX_W'(i)) begin
               case (op_q)
                  OP_SET: s_vec[i] = 1'b1;
                  OP_CLR: r_vec[i] = 1'b1;
                  OP_TGL: begin
                     s_vec[i] = ~q[i];
                     r_vec[i] = q[i];
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   for (genvar g = 0; g < N_CELLS; g++) begin : g_cell
      sr_ff u_cell (
         .clk (clk),
         .rst (rst),
         .s_i (s_vec[g]),
         .r_i (r_vec[g]),
         .q_o (q[g])
      );
   end

   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign done_id  = done & port_q;
   assign done_err = done & idx_oob;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Bench for sr_bank_arbiter: an 8-cell and a 6-cell instance share one stimulus stream.
module tb_sr_bank_arbiter;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] CLR = 2'b01;
  localparam logic [1:0] SET = 2'b10;
  localparam logic [1:0] TGL = 2'b11;
  localparam int EW = 18;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [1:0] req0_op, req1_op;
  logic [2:0] req0_idx, req1_idx;

  logic       rdy0_8, rdy1_8, done_8, id_8, err_8, busy_8;
  logic [7:0] q_8;
  logic       rdy0_6, rdy1_6, done_6, id_6, err_6, busy_6;
  logic [5:0] q_6;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sr_bank_arbiter #(.N_CELLS(8), .IDX_W(3)) dut8 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_idx(req0_idx), .req0_ready(rdy0_8),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_idx(req1_idx), .req1_ready(rdy1_8),
    .done(done_8), .done_id(id_8), .done_err(err_8), .busy(busy_8), .q(q_8)
  );

  sr_bank_arbiter #(.N_CELLS(6), .IDX_W(3)) dut6 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_idx(req0_idx), .req0_ready(rdy0_6),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_idx(req1_idx), .req1_ready(rdy1_6),
    .done(done_6), .done_id(id_6), .done_err(err_6), .busy(busy_6), .q(q_6)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] apply_op(input logic [7:0] qv, input logic [1:0] op,
                                          input logic [2:0] idx, input int n);
    logic [7:0] r;
    r = qv;
    if (int'(idx) < n) begin
      case (op)
        CLR: r[idx] = 1'b0;
        SET: r[idx] = 1'b1;
        TGL: r[idx] = ~r[idx];
        default: ;
      endcase
    end
    return r;
  endfunction

  // ---------------- reference model + scoreboard ----------------
  // entry = {id8, id6, err8, err6, q8[7:0], q6[5:0]}
  logic [EW-1:0] exp_q[$];
  logic          m_valid = 1'b0;
  int            m_state = 0;
  logic          m_last  = 1'b1;
  logic [7:0]    m_q8 = '0, p_q8 = '0, t8;
  logic [5:0]    m_q6 = '0, p_q6 = '0;
  logic          e_r0, e_r1, m_port;
  logic [1:0]    m_op;
  logic [2:0]    m_idx;
  logic [EW-1:0] e_ent;

  always @(negedge clk) begin
    e_r0 = (m_state == 0) && req0_valid && (!req1_valid || m_last);
    e_r1 = (m_state == 0) && req1_valid && (!req0_valid || !m_last);
    if (m_valid) begin
      chk("busy8", busy_8, m_state != 0);
      chk("busy6", busy_6, m_state != 0);
      chk("ready0_8", rdy0_8, e_r0);
      chk("ready1_8", rdy1_8, e_r1);
      chk("ready0_6", rdy0_6, e_r0);
      chk("ready1_6", rdy1_6, e_r1);
      chk("done8", done_8, m_state == 2);
      chk("done6", done_6, m_state == 2);
      if (done_8 || done_6) begin
        if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          e_ent = exp_q.pop_front();
          chk("done_result", {id_8, id_6, err_8, err_6, q_8, q_6}, e_ent);
        end
      end
      chk("q8", q_8, m_q8);
      chk("q6", q_6, m_q6);
      chk("s_and_r_8", |(dut8.s_vec & dut8.r_vec), 0);
      chk("sr_onehot_8", $countones(dut8.s_vec | dut8.r_vec) <= 1, 1);
      chk("s_and_r_6", |(dut6.s_vec & dut6.r_vec), 0);
      chk("sr_onehot_6", $countones(dut6.s_vec | dut6.r_vec) <= 1, 1);
    end
    if (rst) begin
      m_state = 0; m_q8 = '0; m_q6 = '0; m_last = 1'b1;
      exp_q.delete();
      m_valid = 1'b1;
    end else if (m_valid) begin
      case (m_state)
        0: if (e_r0 || e_r1) begin
          m_port = e_r1;
          m_op   = e_r1 ? req1_op  : req0_op;
          m_idx  = e_r1 ? req1_idx : req0_idx;
          p_q8   = apply_op(m_q8, m_op, m_idx, 8);
          t8     = apply_op({2'b00, m_q6}, m_op, m_idx, 6);
          p_q6   = t8[5:0];
          exp_q.push_back({m_port, m_port, 1'b0, (int'(m_idx) >= 6), p_q8, p_q6});
          m_last  = m_port;
          m_state = 1;
        end
        1: begin m_q8 = p_q8; m_q6 = p_q6; m_state = 2; end
        default: m_state = 0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v0, input logic [1:0] o0, input logic [2:0] i0,
                       input logic v1, input logic [1:0] o1, input logic [2:0] i1);
    logic a0, a1;
    req0_valid = v0; req0_op = o0; req0_idx = i0;
    req1_valid = v1; req1_op = o1; req1_idx = i1;
    for (int c = 0; c < 40 && (req0_valid || req1_valid); c++) begin
      @(negedge clk);
      a0 = req0_valid && rdy0_8;
      a1 = req1_valid && rdy1_8;
      @(posedge clk);
      #1;
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
    end
    if (req0_valid || req1_valid) begin
      chk("accept_timeout", 0, 1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_op = NOP; req0_idx = '0;
    req1_valid = 1'b0; req1_op = NOP; req1_idx = '0;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(5);
    chk("reset_q8", q_8, 8'h00);
    chk("reset_busy", busy_8, 0);

    issue(1, SET, 3'd3, 0, NOP, 3'd0);
    wait_cycles(3);
    chk("set3_q8", q_8, 8'h08);
    issue(1, CLR, 3'd3, 0, NOP, 3'd0);
    wait_cycles(3);
    chk("clr3_q8", q_8, 8'h00);

    issue(1, TGL, 3'd5, 1, TGL, 3'd5);
    wait_cycles(3);
    chk("tgl_tgl_q8", q_8, 8'h00);

    do_reset();
    issue(1, SET, 3'd1, 1, SET, 3'd6);
    wait_cycles(3);
    chk("both_set_q8", q_8, 8'h42);
    chk("both_set_q6", q_6, 6'h02);

    issue(0, NOP, 3'd0, 1, SET, 3'd7);
    wait_cycles(3);
    chk("oob_q6", q_6, 6'h02);
    chk("idx7_q8", q_8, 8'hC2);
    issue(0, NOP, 3'd0, 1, NOP, 3'd0);
    wait_cycles(3);
    chk("nop_q8", q_8, 8'hC2);

    for (int k = 0; k < 12; k++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      wait_cycles(3);
    end

    do_reset();
    issue(1, SET, 3'd2, 0, NOP, 3'd0);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(3);
    chk("abort_q8", q_8, 8'h00);
    chk("abort_busy", busy_8, 0);
    chk("scoreboard_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
